// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the byte-serial load/store sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_RSVD  = 2'b11;

    localparam logic [1:0] SEL_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_TAIL = 3'd3,
        ST_DONE      = 3'd4
    } lsu_state_t;

    // Byte count of an access; zero for the reserved size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ext
// Description : Sign/zero extender for right-aligned byte, half and word loads.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_asm,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & i_asm[7]}}, i_asm[7:0]};
            SZ_HALF: o_data = {{16{i_signed & i_asm[15]}}, i_asm[15:0]};
            SZ_WORD: o_data = i_asm;
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_byte_seq.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_seq
// Description : Splits CPU byte/half/word loads and stores into big-endian
//               single-byte accesses on the byte-wide data RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [1:0]        SIZE,
    input  logic              SIGNED,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [1:0]        MEM_SEL,
    output logic              MEM_MW,
    output logic [7:0]        MEM_WDATA,
    input  logic [7:0]        MEM_RBYTE
);

    lsu_state_t        r_state,     w_state_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic              r_mem_mw,    w_mem_mw_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic [31:0]       r_wsh,       w_wsh_nxt;
    logic [31:0]       r_asm,       w_asm_nxt;
    logic [1:0]        r_idx,       w_idx_nxt;
    logic [2:0]        r_n,         w_n_nxt;
    logic              r_first,     w_first_nxt;
    logic              r_we,        w_we_nxt;
    logic [1:0]        r_size,      w_size_nxt;
    logic              r_signed,    w_signed_nxt;

    logic              w_accept;
    logic              w_last;
    logic [31:0]       w_wdata_msb;
    logic [31:0]       w_asm_fin;
    logic [31:0]       w_ext;

    assign w_accept  = REQ && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last    = (({1'b0, r_idx} + 3'd1) == r_n);
    assign w_asm_fin = {r_asm[23:0], MEM_RBYTE};

    // Left-justify the store data so byte 0 always leaves from bits [31:24].
    always_comb begin
        w_wdata_msb = WDATA;
        case (SIZE)
            SZ_BYTE: w_wdata_msb = {WDATA[7:0], 24'h0};
            SZ_HALF: w_wdata_msb = {WDATA[15:0], 16'h0};
            default: w_wdata_msb = WDATA;
        endcase
    end

    lsu_ext u_ext (
        .i_asm    (w_asm_fin),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_mem_mw_nxt    = r_mem_mw;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_wsh_nxt       = r_wsh;
        w_asm_nxt       = r_asm;
        w_idx_nxt       = r_idx;
        w_n_nxt         = r_n;
        w_first_nxt     = r_first;
        w_we_nxt        = r_we;
        w_size_nxt      = r_size;
        w_signed_nxt    = r_signed;

        case (r_state)
            ST_WRITE: begin
                if (w_last) begin
                    w_mem_mw_nxt = 1'b0;
                    w_state_nxt  = ST_DONE;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                end else begin
                    w_idx_nxt       = r_idx + 2'd1;
                    w_mem_addr_nxt  = r_mem_addr + ADDR_W'(1);
                    w_mem_wdata_nxt = r_wsh[23:16];
                    w_wsh_nxt       = {r_wsh[23:0], 8'h0};
                end
            end
            ST_READ: begin
                // The RAM output is one edge behind the address, so the first edge has nothing to capture.
                if (!r_first) begin
                    w_asm_nxt = w_asm_fin;
                end
                w_first_nxt = 1'b0;
                if (w_last) begin
                    w_state_nxt = ST_READ_TAIL;
                end else begin
                    w_idx_nxt      = r_idx + 2'd1;
                    w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                end
            end
            ST_READ_TAIL: begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                if (!r_we) begin
                    w_rdata_nxt = w_ext;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_busy_nxt   = 1'b0;
                w_mem_mw_nxt = 1'b0;
                if (w_accept) begin
                    w_we_nxt     = WE;
                    w_size_nxt   = SIZE;
                    w_signed_nxt = SIGNED;
                    w_n_nxt      = size_bytes(SIZE);
                    w_idx_nxt    = 2'd0;
                    w_first_nxt  = 1'b1;
                    w_asm_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    if (SIZE == SZ_RSVD) begin
                        w_state_nxt = ST_READ_TAIL;
                    end else if (WE) begin
                        w_state_nxt     = ST_WRITE;
                        w_mem_mw_nxt    = 1'b1;
                        w_mem_addr_nxt  = ADDR;
                        w_mem_wdata_nxt = w_wdata_msb[31:24];
                        w_wsh_nxt       = w_wdata_msb;
                    end else begin
                        w_state_nxt    = ST_READ;
                        w_mem_addr_nxt = ADDR;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_mem_mw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wsh       <= '0;
            r_asm       <= '0;
            r_idx       <= '0;
            r_n         <= '0;
            r_first     <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= '0;
            r_signed    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_mw    <= w_mem_mw_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_wsh       <= w_wsh_nxt;
            r_asm       <= w_asm_nxt;
            r_idx       <= w_idx_nxt;
            r_n         <= w_n_nxt;
            r_first     <= w_first_nxt;
            r_we        <= w_we_nxt;
            r_size      <= w_size_nxt;
            r_signed    <= w_signed_nxt;
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign RDATA     = r_rdata;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_SEL   = SEL_BYTE;
    assign MEM_MW    = r_mem_mw;
    assign MEM_WDATA = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_byte_seq
// Description : Directed and random load/store checks against a byte-RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_byte_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [9:0]  ADDR = '0;
    logic [1:0]  SIZE = '0;
    logic        SIGNED = 1'b0;
    logic [31:0] WDATA = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RDATA;
    logic [9:0]  MEM_ADDR;
    logic [1:0]  MEM_SEL;
    logic        MEM_MW;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RBYTE = '0;

    logic [7:0]  ram     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    int          commit_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = '0;

    lsu_byte_seq #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .SIZE(SIZE),
        .SIGNED(SIGNED), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_SEL(MEM_SEL), .MEM_MW(MEM_MW),
        .MEM_WDATA(MEM_WDATA), .MEM_RBYTE(MEM_RBYTE)
    );

    always #5 CLK = ~CLK;

    // Byte RAM with a registered read port.
    always @(posedge CLK) begin
        if (MEM_MW) begin
            ram[MEM_ADDR] <= MEM_WDATA;
            commit_cnt    <= commit_cnt + 1;
        end
        MEM_RBYTE <= ram[MEM_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: model result, latency, write-enable count and RAM contents.
    task automatic run_op(input logic we, input logic [9:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd, input bit b2b);
        int n, exp_lat, lat, c0, nbad;
        bit done_seen;
        logic [31:0] v;
        n       = (sz == 2'b11) ? 0 : (1 << sz);
        exp_lat = (sz == 2'b11) ? 1 : (we ? n : n + 1);
        if (!b2b) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        REQ = 1'b1; WE = we; ADDR = a; SIZE = sz; SIGNED = sg; WDATA = wd;
        c0 = commit_cnt;
        @(posedge CLK);
        #1;
        REQ = 1'b0; WE = $urandom_range(0, 1); ADDR = 10'($urandom);
        SIZE = 2'($urandom); SIGNED = $urandom_range(0, 1); WDATA = $urandom;
        lat = 0;
        done_seen = 0;
        while (!done_seen && lat < 20) begin
            REQ = $urandom_range(0, 1);
            @(posedge CLK);
            #1;
            lat++;
            if (DONE) done_seen = 1;
        end
        REQ = 1'b0;
        if (we && sz != 2'b11) begin
            for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 1024] = wd[8*(n-1-k) +: 8];
        end else if (!we) begin
            v = '0;
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[(int'(a) + k) % 1024]);
            if (sz == 2'b00 && sg && v[7])  v = v | 32'hFFFF_FF00;
            if (sz == 2'b01 && sg && v[15]) v = v | 32'hFFFF_0000;
            exp_rdata = v;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_at_done", {31'h0, BUSY}, 32'h0);
        check("mw_cycles", 32'(commit_cnt - c0), (we && sz != 2'b11) ? 32'(n) : 32'h0);
        check("rdata", RDATA, exp_rdata);
        check("mem_sel", {30'h0, MEM_SEL}, 32'h2);
        nbad = 0;
        for (int k = 0; k < 4; k++)
            if (ram[(int'(a) + k) % 1024] !== ref_mem[(int'(a) + k) % 1024]) nbad++;
        check("ram_bytes", 32'(nbad), 32'h0);
    endtask

    initial begin
        int c0, nbad;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_done", {31'h0, DONE}, 32'h0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_mw", {31'h0, MEM_MW}, 32'h0);
        check("rst_addr", {22'h0, MEM_ADDR}, 32'h0);
        check("rst_wdata", {24'h0, MEM_WDATA}, 32'h0);
        check("rst_sel", {30'h0, MEM_SEL}, 32'h2);
        @(negedge CLK);
        RST_N = 1'b1;

        // Word store across the address wrap, then read it back.
        run_op(1'b1, 10'h3FE, 2'b10, 1'b0, 32'hDEADBEEF, 0);
        run_op(1'b0, 10'h3FE, 2'b10, 1'b1, 32'h0, 0);
        check("word_wrap_load", RDATA, 32'hDEADBEEF);

        // Byte 0x80 sign/zero extension.
        run_op(1'b1, 10'h010, 2'b00, 1'b0, 32'h5A5A5A80, 0);
        run_op(1'b0, 10'h010, 2'b00, 1'b1, 32'h0, 0);
        check("byte_signed", RDATA, 32'hFFFFFF80);
        run_op(1'b0, 10'h010, 2'b00, 1'b0, 32'h0, 0);
        check("byte_unsigned", RDATA, 32'h00000080);

        // Half load of BE,EF left at 0x000 by the wrapped word store.
        run_op(1'b0, 10'h000, 2'b01, 1'b1, 32'h0, 0);
        check("half_signed", RDATA, 32'hFFFFBEEF);
        run_op(1'b0, 10'h000, 2'b01, 1'b0, 32'h0, 0);
        check("half_unsigned", RDATA, 32'h0000BEEF);

        // Byte load followed by a half store issued in its DONE cycle.
        run_op(1'b0, 10'h010, 2'b00, 1'b1, 32'h0, 0);
        run_op(1'b1, 10'h020, 2'b01, 1'b0, 32'hFFFF1234, 1);
        check("b2b_ram20", {24'h0, ram[10'h020]}, 32'h12);
        check("b2b_ram21", {24'h0, ram[10'h021]}, 32'h34);

        // Reset in the middle of a word store after two committed bytes.
        @(posedge CLK);
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; ADDR = 10'h040; SIZE = 2'b10; SIGNED = 1'b0; WDATA = 32'hAABBCCDD;
        c0 = commit_cnt;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_mw", {31'h0, MEM_MW}, 32'h0);
        check("midrst_busy", {31'h0, BUSY}, 32'h0);
        check("midrst_rdata", RDATA, 32'h0);
        check("midrst_addr", {22'h0, MEM_ADDR}, 32'h0);
        ref_mem[10'h040] = 8'hAA;
        ref_mem[10'h041] = 8'hBB;
        exp_rdata = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("midrst_commits", 32'(commit_cnt - c0), 32'h2);
        run_op(1'b0, 10'h040, 2'b10, 1'b0, 32'h0, 0);

        // Reserved size: store keeps RDATA, load clears it.
        run_op(1'b1, 10'h100, 2'b11, 1'b0, 32'h11223344, 0);
        run_op(1'b0, 10'h100, 2'b11, 1'b1, 32'h0, 0);
        check("rsvd_rdata", RDATA, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_op($urandom_range(0, 1), 10'($urandom), 2'($urandom), $urandom_range(0, 1),
                   $urandom, $urandom_range(0, 1) == 1);
        end

        nbad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) nbad++;
        check("ram_all", 32'(nbad), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
